// File: rtl/puc_pkg.sv
// Shared types for the PUC switching-state sequencer: state index,
// one-hot selector, sequencer FSM encoding and the index-to-selector map.
package puc_pkg;

  // Index of a converter switching state, 0 selects s1 ... 7 selects s8.
  typedef logic [2:0] puc_idx_t;

  // Selector bus {s1..s8}; s1 is the MSB, all-zero means every switch off.
  typedef logic [7:0] puc_sel_t;

  // Sequencer control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    APPLY = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } puc_fsm_t;

  // Maps a state index to its selector pattern. Index 0 drives s1, which
  // sits in the MSB, so the single set bit walks down as the index grows.
  function automatic puc_sel_t idx2onehot(input puc_idx_t idx);
    puc_sel_t msb;
    msb = 8'b1000_0000;
    return msb >> idx;
  endfunction

endpackage

// File: rtl/puc_state_sequencer_if.sv
// Request/selector bundle between a state requester (master) and the
// PUC state sequencer (slave). Fault inputs travel with the request side
// because the same supervisor that requests states also reports faults.
interface puc_state_sequencer_if;
  import puc_pkg::*;

  logic     req_valid;
  puc_idx_t req_state;
  logic     req_ready;
  logic     fault;
  logic     clr_fault;
  puc_sel_t sel;
  puc_idx_t cur_state;
  logic     applied;
  logic     fault_latched;

  // Requester / supervisor side.
  modport master (
    output req_valid,
    output req_state,
    output fault,
    output clr_fault,
    input  req_ready,
    input  sel,
    input  cur_state,
    input  applied,
    input  fault_latched
  );

  // Sequencer side.
  modport slave (
    input  req_valid,
    input  req_state,
    input  fault,
    input  clr_fault,
    output req_ready,
    output sel,
    output cur_state,
    output applied,
    output fault_latched
  );

endinterface

// File: rtl/puc_state_sequencer.sv
// PUC switching-state sequencer. Accepts a requested state index over a
// valid/ready handshake and drives a registered one-hot selector to the
// switching decoder. Between two different states the selector is forced
// all-off for DEAD_CYC cycles, every newly applied state is held for
// MIN_DWELL cycles before another request is taken, and a fault drops the
// selector to all-off until the fault is gone and explicitly cleared.
module puc_state_sequencer
  import puc_pkg::*;
#(
  parameter int unsigned DEAD_CYC  = 20,
  parameter int unsigned MIN_DWELL = 100,
  parameter int unsigned CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rst,
  puc_state_sequencer_if.slave bus
);

  // Timer reload values; the timer counts down to zero inclusive, so a
  // load of N-1 gives a phase that lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(MIN_DWELL - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

  puc_fsm_t         fsm_q,   fsm_d;
  puc_sel_t         sel_q,   sel_d;
  puc_idx_t         cur_q,   cur_d;
  puc_idx_t         tgt_q,   tgt_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic readyNow;
  logic acceptReq;
  logic timerDone;

  // Requests are only taken while idle or holding a dwelled state, and a
  // live fault blocks acceptance in the same cycle so it always wins.
  always_comb begin
    readyNow  = ((fsm_q == IDLE) || (fsm_q == HOLD)) && !bus.fault;
    acceptReq = bus.req_valid && readyNow;
    timerDone = (timer_q == '0);
  end

  // Next-state logic. A fault overrides everything: the selector goes
  // all-off and any pending target or partial timing is thrown away.
  // The selector only ever moves between all-off and a single one-hot
  // pattern, never straight from one pattern to another.
  always_comb begin
    fsm_d   = fsm_q;
    sel_d   = sel_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    timer_d = timer_q;

    if (bus.fault) begin
      fsm_d   = FAULT;
      sel_d   = '0;
      tgt_d   = '0;
      timer_d = '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          sel_d = '0;
          if (acceptReq) begin
            fsm_d   = APPLY;
            sel_d   = idx2onehot(bus.req_state);
            cur_d   = bus.req_state;
            timer_d = DWELL_LOAD;
          end
        end

        APPLY: begin
          if (timerDone) begin
            fsm_d = HOLD;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end

        HOLD: begin
          if (acceptReq && (bus.req_state != cur_q)) begin
            fsm_d   = DEAD;
            sel_d   = '0;
            tgt_d   = bus.req_state;
            timer_d = DEAD_LOAD;
          end
        end

        DEAD: begin
          sel_d = '0;
          if (timerDone) begin
            fsm_d   = APPLY;
            sel_d   = idx2onehot(tgt_q);
            cur_d   = tgt_q;
            timer_d = DWELL_LOAD;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end

        FAULT: begin
          sel_d   = '0;
          tgt_d   = '0;
          timer_d = '0;
          if (bus.clr_fault) begin
            fsm_d = IDLE;
          end
        end

        default: begin
          fsm_d   = IDLE;
          sel_d   = '0;
          tgt_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, selector, target and timer registers; reset forces all-off at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      sel_q   <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      timer_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      timer_q <= timer_d;
    end
  end

  assign bus.req_ready     = readyNow;
  assign bus.sel           = sel_q;
  assign bus.cur_state     = cur_q;
  assign bus.applied       = |sel_q;
  assign bus.fault_latched = (fsm_q == FAULT);

endmodule
